// File: rtl/vram_arb_pkg.sv
// Shared types and slot-phase constants for the VRAM slot arbiter.
package vram_arb_pkg;

   typedef enum logic [2:0] {
      OWN_IDLE = 3'd0,
      OWN_PF   = 3'd1,
      OWN_MO   = 3'd2,
      OWN_AL   = 3'd3,
      OWN_CPU  = 3'd4
   } owner_t;

   localparam logic [2:0] PH_PF  = 3'd0;
   localparam logic [2:0] PH_MO  = 3'd2;
   localparam logic [2:0] PH_AL  = 3'd4;
   localparam logic [2:0] PH_CPU = 3'd6;

   // Owner for the slot that begins at even phase ph. During VBLANK the CPU
   // may take any slot; otherwise it only competes for the last one.
   function automatic owner_t pick_owner(
      input logic [2:0] ph,
      input logic       vblank,
      input logic       cpu_req,
      input logic       mo_req
   );
      owner_t o;
      o = OWN_IDLE;
      case (ph)
         PH_PF:   o = OWN_PF;
         PH_MO:   o = mo_req ? OWN_MO : OWN_IDLE;
         PH_AL:   o = OWN_AL;
         PH_CPU:  o = cpu_req ? OWN_CPU : (mo_req ? OWN_MO : OWN_IDLE);
         default: o = OWN_IDLE;
      endcase
      if (vblank && cpu_req) begin
         o = OWN_CPU;
      end
      return o;
   endfunction

endpackage

// File: rtl/vram_slot_counter.sv
// Purpose: 3-bit slot phase counter, LINE_START reloads phase 0 on the next edge.
// Latency: PHASE updates one edge after LINE_START.
// Backpressure: none, free-running.
module vram_slot_counter
   import vram_arb_pkg::*;
(
   input  logic       MCKF,
   input  logic       RESET_b,
   input  logic       LINE_START,
   output logic [2:0] PHASE,
   output logic       ADDR_PH,
   output logic       DATA_PH
);

   always_ff @(posedge MCKF or negedge RESET_b) begin
      if (!RESET_b) begin
         PHASE <= PH_PF;
      end else if (LINE_START) begin
         PHASE <= PH_PF;
      end else begin
         PHASE <= PHASE + 3'd1;
      end
   end

   assign ADDR_PH = ~PHASE[0];
   assign DATA_PH =  PHASE[0];

endmodule

// File: rtl/vram_slot_arbiter.sv
// Purpose: four 2-clock VRAM slots per 8-clock group (PF, MO, AL, CPU), drives VRAM and latch strobes.
// Latency: owner/address registered entering the even phase; strobe in the odd phase; CPU_ACK the cycle after.
// Backpressure: CPU holds CPU_REQ until CPU_ACK; LINE_START in a data phase aborts it with no ACK.
module vram_slot_arbiter
   import vram_arb_pkg::*;
#(
   parameter int AW = 14,
   parameter int DW = 16
) (
   input  logic          MCKF,
   input  logic          RESET_b,
   input  logic          LINE_START,
   input  logic          VBLANK,
   input  logic [AW-1:0] PF_ADDR,
   input  logic [AW-1:0] MO_ADDR,
   input  logic          MO_REQ,
   input  logic [AW-1:0] AL_ADDR,
   input  logic          CPU_REQ,
   input  logic          CPU_WE,
   input  logic [AW-1:0] CPU_ADDR,
   input  logic [DW-1:0] CPU_WDATA,
   input  logic [DW-1:0] VRD,
   output logic [AW-1:0] VRA,
   output logic          VRAM_OE_b,
   output logic          VRAM_WE_b,
   output logic [DW-1:0] VRD_OUT,
   output logic          VRD_DRV,
   output logic          PF_LD_b,
   output logic          MO_LD_b,
   output logic          AL_LD_b,
   output logic          CPU_ACK,
   output logic [DW-1:0] CPU_RDATA,
   output owner_t        OWNER
);

   logic [2:0] phase;
   logic       addr_ph;
   logic       data_ph;

   vram_slot_counter u_slot_counter (
      .MCKF       (MCKF),
      .RESET_b    (RESET_b),
      .LINE_START (LINE_START),
      .PHASE      (phase),
      .ADDR_PH    (addr_ph),
      .DATA_PH    (data_ph)
   );

   owner_t        owner_q,   owner_d;
   logic          cpu_we_q,  cpu_we_d;
   logic [AW-1:0] vra_q,     vra_d;
   logic [DW-1:0] wdata_q,   wdata_d;
   logic [DW-1:0] rdata_q,   rdata_d;
   logic          oe_b_q,    oe_b_d;
   logic          we_b_q,    we_b_d;
   logic          drv_q,     drv_d;
   logic          pf_ld_b_q, pf_ld_b_d;
   logic          mo_ld_b_q, mo_ld_b_d;
   logic          al_ld_b_q, al_ld_b_d;
   logic          ack_q,     ack_d;

   logic          enter_data;
   logic          cpu_done;
   logic          cpu_elig;
   logic [2:0]    slot_ph;

   // Any edge that does not land on an odd phase opens a new slot.
   assign enter_data = addr_ph & ~LINE_START;
   assign slot_ph    = LINE_START ? PH_PF : phase + 3'd1;

   // The request still held during a completing CPU slot is the old one,
   // so it may not win the slot that begins on that same edge.
   assign cpu_done = (owner_q == OWN_CPU) && data_ph && !LINE_START;
   assign cpu_elig = CPU_REQ && !cpu_done;

   always_ff @(posedge MCKF or negedge RESET_b) begin
      if (!RESET_b) begin
         owner_q   <= OWN_IDLE;
         cpu_we_q  <= 1'b0;
         vra_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         oe_b_q    <= 1'b1;
         we_b_q    <= 1'b1;
         drv_q     <= 1'b0;
         pf_ld_b_q <= 1'b1;
         mo_ld_b_q <= 1'b1;
         al_ld_b_q <= 1'b1;
         ack_q     <= 1'b0;
      end else begin
         owner_q   <= owner_d;
         cpu_we_q  <= cpu_we_d;
         vra_q     <= vra_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         oe_b_q    <= oe_b_d;
         we_b_q    <= we_b_d;
         drv_q     <= drv_d;
         pf_ld_b_q <= pf_ld_b_d;
         mo_ld_b_q <= mo_ld_b_d;
         al_ld_b_q <= al_ld_b_d;
         ack_q     <= ack_d;
      end
   end

   always_comb begin
      owner_d   = owner_q;
      cpu_we_d  = cpu_we_q;
      vra_d     = vra_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      oe_b_d    = oe_b_q;
      drv_d     = drv_q;
      we_b_d    = 1'b1;
      pf_ld_b_d = 1'b1;
      mo_ld_b_d = 1'b1;
      al_ld_b_d = 1'b1;
      ack_d     = 1'b0;

      if (enter_data) begin
         case (owner_q)
            OWN_PF:  pf_ld_b_d = 1'b0;
            OWN_MO:  mo_ld_b_d = 1'b0;
            OWN_AL:  al_ld_b_d = 1'b0;
            OWN_CPU: we_b_d    = ~cpu_we_q;
            default: ;
         endcase
      end else begin
         owner_d = pick_owner(slot_ph, VBLANK, cpu_elig, MO_REQ);
         oe_b_d  = 1'b1;
         drv_d   = 1'b0;
         case (owner_d)
            OWN_PF: begin
               vra_d  = PF_ADDR;
               oe_b_d = 1'b0;
            end
            OWN_MO: begin
               vra_d  = MO_ADDR;
               oe_b_d = 1'b0;
            end
            OWN_AL: begin
               vra_d  = AL_ADDR;
               oe_b_d = 1'b0;
            end
            OWN_CPU: begin
               vra_d    = CPU_ADDR;
               cpu_we_d = CPU_WE;
               oe_b_d   = CPU_WE;
               drv_d    = CPU_WE;
               if (CPU_WE) begin
                  wdata_d = CPU_WDATA;
               end
            end
            default: ;
         endcase

         if (cpu_done) begin
            ack_d = 1'b1;
            if (!cpu_we_q) begin
               rdata_d = VRD;
            end
         end
      end
   end

   // A LINE_START arriving inside a data phase must kill that cycle's strobes.
   always_comb begin
      VRA       = vra_q;
      VRAM_OE_b = oe_b_q;
      VRAM_WE_b = we_b_q | LINE_START;
      VRD_OUT   = wdata_q;
      VRD_DRV   = drv_q;
      PF_LD_b   = pf_ld_b_q | LINE_START;
      MO_LD_b   = mo_ld_b_q | LINE_START;
      AL_LD_b   = al_ld_b_q | LINE_START;
      CPU_ACK   = ack_q;
      CPU_RDATA = rdata_q;
      OWNER     = owner_q;
   end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter: slot sequencing, CPU handshake scoreboard, abort and reset.
module tb_vram_slot_arbiter;
   import vram_arb_pkg::*;

   localparam int AW = 14;
   localparam int DW = 16;

   logic          MCKF = 1'b0;
   logic          RESET_b, LINE_START, VBLANK, MO_REQ, CPU_REQ, CPU_WE;
   logic [AW-1:0] PF_ADDR, MO_ADDR, AL_ADDR, CPU_ADDR, VRA;
   logic [DW-1:0] CPU_WDATA, VRD, VRD_OUT, CPU_RDATA;
   logic          VRAM_OE_b, VRAM_WE_b, VRD_DRV, PF_LD_b, MO_LD_b, AL_LD_b, CPU_ACK;
   logic [2:0]    OWNER;

   typedef struct {
      logic          we;
      logic [DW-1:0] data;
   } sb_t;

   sb_t        exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [2:0] tph = 3'd0;

   vram_slot_arbiter #(.AW(AW), .DW(DW)) dut (
      .MCKF(MCKF), .RESET_b(RESET_b), .LINE_START(LINE_START), .VBLANK(VBLANK),
      .PF_ADDR(PF_ADDR), .MO_ADDR(MO_ADDR), .MO_REQ(MO_REQ), .AL_ADDR(AL_ADDR),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
      .VRD(VRD), .VRA(VRA), .VRAM_OE_b(VRAM_OE_b), .VRAM_WE_b(VRAM_WE_b),
      .VRD_OUT(VRD_OUT), .VRD_DRV(VRD_DRV), .PF_LD_b(PF_LD_b), .MO_LD_b(MO_LD_b),
      .AL_LD_b(AL_LD_b), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA), .OWNER(OWNER)
   );

   always #5 MCKF = ~MCKF;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (bench phase %0d)", tag, obs, exp, tph);
      end
   endtask

   // Step past the next rising edge; the bench tracks the phase it expects.
   task automatic adv();
      logic ls, rst;
      ls  = LINE_START;
      rst = RESET_b;
      @(posedge MCKF);
      #1;
      tph = (!rst || ls) ? 3'd0 : tph + 3'd1;
      LINE_START = 1'b0;
   endtask

   // Sample on the falling edge; any ACK retires the oldest expected CPU access.
   task automatic smp();
      sb_t e;
      @(negedge MCKF);
      if (CPU_ACK === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(CPU_ACK), 32'd0);
         end else begin
            e = exp_q.pop_front();
            if (e.we) chk("ack_wdata", 32'(VRD_OUT), 32'(e.data));
            else      chk("ack_rdata", 32'(CPU_RDATA), 32'(e.data));
         end
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         adv();
         smp();
      end
   endtask

   initial begin
      RESET_b = 1'b0; LINE_START = 1'b0; VBLANK = 1'b0; MO_REQ = 1'b0;
      CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0; VRD = '0;
      PF_ADDR = 14'h0111; MO_ADDR = 14'h0222; AL_ADDR = 14'h0333;

      // Reset state
      smp(); smp();
      chk("rst_vra",   32'(VRA), 32'd0);
      chk("rst_oe",    32'(VRAM_OE_b), 32'd1);
      chk("rst_we",    32'(VRAM_WE_b), 32'd1);
      chk("rst_drv",   32'(VRD_DRV), 32'd0);
      chk("rst_ld",    32'({PF_LD_b, MO_LD_b, AL_LD_b}), 32'd7);
      chk("rst_ack",   32'(CPU_ACK), 32'd0);
      chk("rst_owner", 32'(OWNER), 32'(OWN_IDLE));
      adv(); RESET_b = 1'b1; smp();
      adv(); LINE_START = 1'b1; smp();

      // Idle line: PF and AL only
      tick(1);
      chk("idle_p0_owner", 32'(OWNER), 32'(OWN_PF));
      chk("idle_p0_vra",   32'(VRA), 32'h0111);
      chk("idle_p0_oe",    32'(VRAM_OE_b), 32'd0);
      chk("idle_p0_pfld",  32'(PF_LD_b), 32'd1);
      tick(1);
      chk("idle_p1_pfld",  32'(PF_LD_b), 32'd0);
      chk("idle_p1_vra",   32'(VRA), 32'h0111);
      tick(1);
      chk("idle_p2_oe",    32'(VRAM_OE_b), 32'd1);
      chk("idle_p2_owner", 32'(OWNER), 32'(OWN_IDLE));
      chk("idle_p2_vra",   32'(VRA), 32'h0111);
      tick(1);
      chk("idle_p3_oe",    32'(VRAM_OE_b), 32'd1);
      chk("idle_p3_mold",  32'(MO_LD_b), 32'd1);
      tick(1);
      chk("idle_p4_vra",   32'(VRA), 32'h0333);
      tick(1);
      chk("idle_p5_alld",  32'(AL_LD_b), 32'd0);
      tick(1);
      chk("idle_p6_oe",    32'(VRAM_OE_b), 32'd1);
      tick(1);
      chk("idle_p7_oe",    32'(VRAM_OE_b), 32'd1);

      // CPU read raised at phase 3, served in the phase-6 slot
      tick(3);
      adv();
      CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h1234; VRD = 16'hBEEF;
      exp_q.push_back('{we: 1'b0, data: 16'hBEEF});
      smp();
      tick(3);
      chk("rd_p6_owner", 32'(OWNER), 32'(OWN_CPU));
      chk("rd_p6_vra",   32'(VRA), 32'h1234);
      chk("rd_p6_oe",    32'(VRAM_OE_b), 32'd0);
      tick(1);
      chk("rd_p7_oe",    32'(VRAM_OE_b), 32'd0);
      chk("rd_p7_we",    32'(VRAM_WE_b), 32'd1);
      tick(1);
      chk("rd_p0_ack",   32'(CPU_ACK), 32'd1);
      chk("rd_p0_rdata", 32'(CPU_RDATA), 32'hBEEF);
      CPU_REQ = 1'b0; VRD = 16'h0000;
      tick(1);
      chk("rd_p1_ack",   32'(CPU_ACK), 32'd0);
      chk("rd_p1_hold",  32'(CPU_RDATA), 32'hBEEF);

      // VBLANK write raised at phase 1, granted at phase 2
      VBLANK = 1'b1; CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 14'h0042; CPU_WDATA = 16'hA5A5;
      exp_q.push_back('{we: 1'b1, data: 16'hA5A5});
      tick(1);
      chk("wr_p2_owner", 32'(OWNER), 32'(OWN_CPU));
      chk("wr_p2_vra",   32'(VRA), 32'h0042);
      chk("wr_p2_drv",   32'(VRD_DRV), 32'd1);
      chk("wr_p2_we",    32'(VRAM_WE_b), 32'd1);
      chk("wr_p2_oe",    32'(VRAM_OE_b), 32'd1);
      chk("wr_p2_wdata", 32'(VRD_OUT), 32'hA5A5);
      tick(1);
      chk("wr_p3_we",    32'(VRAM_WE_b), 32'd0);
      chk("wr_p3_drv",   32'(VRD_DRV), 32'd1);
      tick(1);
      chk("wr_p4_ack",   32'(CPU_ACK), 32'd1);
      chk("wr_p4_we",    32'(VRAM_WE_b), 32'd1);
      chk("wr_p4_drv",   32'(VRD_DRV), 32'd0);
      chk("wr_p4_owner", 32'(OWNER), 32'(OWN_AL));
      CPU_REQ = 1'b0; VBLANK = 1'b0; MO_REQ = 1'b1;

      // MO takes its own slot and the idle CPU slot
      tick(1);
      chk("mo_p5_alld",  32'(AL_LD_b), 32'd0);
      tick(1);
      chk("mo_p6_owner", 32'(OWNER), 32'(OWN_MO));
      chk("mo_p6_vra",   32'(VRA), 32'h0222);
      tick(1);
      chk("mo_p7_mold",  32'(MO_LD_b), 32'd0);
      tick(3);
      chk("mo_p2_owner", 32'(OWNER), 32'(OWN_MO));
      chk("mo_p2_vra",   32'(VRA), 32'h0222);
      MO_REQ = 1'b0;
      tick(1);
      chk("mo_p3_mold",  32'(MO_LD_b), 32'd0);
      tick(3);
      chk("mo_p6_idle",  32'(OWNER), 32'(OWN_IDLE));
      chk("mo_p6_vra",   32'(VRA), 32'h0333);
      chk("mo_p6_oe",    32'(VRAM_OE_b), 32'd1);

      // LINE_START in the AL data phase
      tick(6);
      chk("ab_p4_owner", 32'(OWNER), 32'(OWN_AL));
      adv();
      LINE_START = 1'b1;
      smp();
      chk("ab_p5_alld",  32'(AL_LD_b), 32'd1);
      tick(1);
      chk("ab_p0_owner", 32'(OWNER), 32'(OWN_PF));
      chk("ab_p0_vra",   32'(VRA), 32'h0111);
      tick(1);
      chk("ab_p1_pfld",  32'(PF_LD_b), 32'd0);

      // LINE_START in a CPU write data phase, then retry
      CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 14'h0777; CPU_WDATA = 16'h5A5A;
      exp_q.push_back('{we: 1'b1, data: 16'h5A5A});
      tick(5);
      chk("abw_p6_owner", 32'(OWNER), 32'(OWN_CPU));
      chk("abw_p6_vra",   32'(VRA), 32'h0777);
      chk("abw_p6_drv",   32'(VRD_DRV), 32'd1);
      adv();
      chk("abw_p7_we_lo", 32'(VRAM_WE_b), 32'd0);
      LINE_START = 1'b1;
      #1;
      chk("abw_p7_we_hi", 32'(VRAM_WE_b), 32'd1);
      smp();
      tick(1);
      chk("abw_p0_noack", 32'(CPU_ACK), 32'd0);
      chk("abw_p0_owner", 32'(OWNER), 32'(OWN_PF));
      tick(6);
      chk("rty_p6_owner", 32'(OWNER), 32'(OWN_CPU));
      tick(1);
      chk("rty_p7_we",    32'(VRAM_WE_b), 32'd0);
      tick(1);
      chk("rty_p0_ack",   32'(CPU_ACK), 32'd1);
      CPU_REQ = 1'b0;

      // Async reset in phase 7 of a CPU write
      CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 14'h0999; CPU_WDATA = 16'h1357;
      exp_q.push_back('{we: 1'b1, data: 16'h1357});
      tick(6);
      chk("rs_p6_owner", 32'(OWNER), 32'(OWN_CPU));
      tick(1);
      chk("rs_p7_we",    32'(VRAM_WE_b), 32'd0);
      #2;
      RESET_b = 1'b0;
      #1;
      chk("rs_async_we",    32'(VRAM_WE_b), 32'd1);
      chk("rs_async_drv",   32'(VRD_DRV), 32'd0);
      chk("rs_async_owner", 32'(OWNER), 32'(OWN_IDLE));
      chk("rs_async_vra",   32'(VRA), 32'd0);
      chk("rs_async_wdata", 32'(VRD_OUT), 32'd0);
      chk("rs_async_rdata", 32'(CPU_RDATA), 32'd0);
      exp_q.delete();
      CPU_REQ = 1'b0;
      adv();
      RESET_b = 1'b1;
      smp();
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("rs_noack", 32'(CPU_ACK), 32'd0);
      end

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
